branch_predictor: RTL and testbench

Branch prediction and resolution unit for the pipelined RV32I core: the next generation of the EX-stage next-PC control. It predicts the next PC for each IF-stage fetch from a parametrised direct-mapped BTB with 2-bit saturating counters. In EX it resolves all six conditional branches plus `jal`/`jalr`, raises a redirect/flush on misprediction, and trains the tables. It sits between the IF PC mux (prediction path) and the EX stage (resolution path).

---
 rtl/branch_predictor.sv | 125 ++++++++++++
 tb/tb_branch_predictor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Next-PC prediction and EX-stage branch resolution: direct-mapped BTB with
// 2-bit saturating counters, mispredict redirect/flush and performance counters.
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int CNT_W   = 32
) (
   input  logic             cpu_clk,
   input  logic             cpu_rst_n,
   input  logic             pred_en,
   input  logic [31:0]      if_pc,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   input  logic             ex_valid,
   input  logic [31:0]      ex_pc,
   input  logic             ex_is_branch,
   input  logic [2:0]       ex_funct3,
   input  logic [1:0]       ex_jump,
   input  logic             ex_zero,
   input  logic             ex_sgn,
   input  logic             ex_ult,
   input  logic [31:0]      ex_pcimm,
   input  logic [31:0]      ex_alu_c,
   input  logic             ex_pred_taken,
   input  logic [31:0]      ex_pred_target,
   output logic             npc_op,
   output logic [31:0]      npc_bj,
   output logic             flush,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mis_cnt
);
   localparam int IDX_W = $clog2(ENTRIES);

   logic [ENTRIES-1:0] valid;
   logic [ENTRIES-1:0] uncond;
   logic [TAG_W-1:0]   tag    [ENTRIES];
   logic [1:0]         ctr    [ENTRIES];
   logic [31:0]        target [ENTRIES];

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit;

   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

   assign if_hit = valid[if_idx] & (tag[if_idx] == if_tag);
   assign ex_hit = valid[ex_idx] & (tag[ex_idx] == ex_tag);

   // valid is cleared asynchronously, so a miss already covers the reset case
   assign pred_taken  = pred_en & if_hit & (uncond[if_idx] | ctr[if_idx][1]);
   assign pred_target = pred_taken ? target[if_idx] : if_pc + 32'd4;

   logic        ex_live, cond, act_taken, mispred, train, alias_clr, is_ctl;
   logic [31:0] act_target;

   always_comb begin
      cond = 1'b0;
      case (ex_funct3)
         3'b000:  cond = ex_zero;
         3'b001:  cond = ~ex_zero;
         3'b100:  cond = ex_sgn;
         3'b101:  cond = ~ex_sgn;
         3'b110:  cond = ex_ult;
         3'b111:  cond = ~ex_ult;
         default: cond = 1'b0;
      endcase
   end

   assign ex_live    = ex_valid & cpu_rst_n;
   assign is_ctl     = ex_is_branch | ex_jump[0];
   assign act_taken  = ex_jump[0] | (ex_is_branch & cond);
   assign act_target = (ex_jump == 2'b01) ? {ex_alu_c[31:1], 1'b0} : ex_pcimm;
   assign mispred    = ex_live & ((act_taken != ex_pred_taken) |
                                  (act_taken & (act_target != ex_pred_target)));
   assign train      = ex_live & is_ctl;
   // a taken prediction on a non-control instruction means the entry aliased
   assign alias_clr  = mispred & ~is_ctl;

   assign npc_op = mispred;
   assign flush  = mispred;
   assign npc_bj = (act_taken & cpu_rst_n) ? act_target : ex_pc + 32'd4;

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         valid  <= '0;
         uncond <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag[i]    <= '0;
            ctr[i]    <= 2'b01;
            target[i] <= '0;
         end
      end else if (train) begin
         if (act_taken) begin
            valid[ex_idx]  <= 1'b1;
            tag[ex_idx]    <= ex_tag;
            uncond[ex_idx] <= ex_jump[0];
            target[ex_idx] <= act_target;
            if (!ex_hit)
               ctr[ex_idx] <= 2'b10;
            else if (ctr[ex_idx] != 2'b11)
               ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
         end else if (ex_hit && ctr[ex_idx] != 2'b00) begin
            ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
         end
      end else if (alias_clr) begin
         valid[ex_idx] <= 1'b0;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         br_cnt  <= '0;
         mis_cnt <= '0;
      end else begin
         if (train && br_cnt != '1)
            br_cnt <= br_cnt + CNT_W'(1);
         if (mispred && mis_cnt != '1)
            mis_cnt <= mis_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations are queued with each
// stimulus step and drained against the outputs mid-cycle.
module tb_branch_predictor;
   localparam int CNT_W = 32;

   logic             cpu_clk = 1'b0;
   logic             cpu_rst_n;
   logic             pred_en;
   logic [31:0]      if_pc;
   logic             pred_taken;
   logic [31:0]      pred_target;
   logic             ex_valid;
   logic [31:0]      ex_pc;
   logic             ex_is_branch;
   logic [2:0]       ex_funct3;
   logic [1:0]       ex_jump;
   logic             ex_zero, ex_sgn, ex_ult;
   logic [31:0]      ex_pcimm, ex_alu_c;
   logic             ex_pred_taken;
   logic [31:0]      ex_pred_target;
   logic             npc_op;
   logic [31:0]      npc_bj;
   logic             flush;
   logic [CNT_W-1:0] br_cnt, mis_cnt;

   branch_predictor #(.ENTRIES(16), .TAG_W(8), .CNT_W(CNT_W)) dut (
      .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .pred_en(pred_en), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_target(pred_target), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_funct3(ex_funct3),
      .ex_jump(ex_jump), .ex_zero(ex_zero), .ex_sgn(ex_sgn), .ex_ult(ex_ult),
      .ex_pcimm(ex_pcimm), .ex_alu_c(ex_alu_c), .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target), .npc_op(npc_op), .npc_bj(npc_bj),
      .flush(flush), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef enum int {S_PTK, S_PTGT, S_OP, S_BJ, S_FL, S_BR, S_MIS} sel_t;
   typedef struct {
      string       tag;
      sel_t        sel;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   logic [31:0] exp_br = 0;
   logic [31:0] exp_mis = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] observe(input sel_t s);
      case (s)
         S_PTK:   return {31'd0, pred_taken};
         S_PTGT:  return pred_target;
         S_OP:    return {31'd0, npc_op};
         S_BJ:    return npc_bj;
         S_FL:    return {31'd0, flush};
         S_BR:    return br_cnt;
         default: return mis_cnt;
      endcase
   endfunction

   task automatic push(input string tag, input sel_t s, input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.sel = s; e.val = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, observe(e.sel), e.val);
      end
   endtask

   task automatic next_cycle();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic push_lookup(input string tag, input logic [31:0] pc,
                              input logic tk, input logic [31:0] tgt);
      if_pc = pc;
      push({tag, ".ptk"}, S_PTK, {31'd0, tk});
      push({tag, ".ptgt"}, S_PTGT, tgt);
   endtask

   task automatic look(input string tag, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tgt);
      push_lookup(tag, pc, tk, tgt);
      push({tag, ".br"}, S_BR, exp_br);
      push({tag, ".mis"}, S_MIS, exp_mis);
      #2;
      drain();
      next_cycle();
   endtask

   task automatic resolve(input string tag, input logic [31:0] pc, input logic is_br,
                          input logic [2:0] f3, input logic [1:0] jmp,
                          input logic z, input logic s, input logic u,
                          input logic [31:0] pcimm, input logic [31:0] aluc,
                          input logic ptk, input logic [31:0] ptgt,
                          input logic op, input logic [31:0] bj);
      ex_valid = 1'b1; ex_pc = pc; ex_is_branch = is_br; ex_funct3 = f3; ex_jump = jmp;
      ex_zero = z; ex_sgn = s; ex_ult = u; ex_pcimm = pcimm; ex_alu_c = aluc;
      ex_pred_taken = ptk; ex_pred_target = ptgt;
      push({tag, ".op"}, S_OP, {31'd0, op});
      push({tag, ".flush"}, S_FL, {31'd0, op});
      push({tag, ".bj"}, S_BJ, bj);
      #2;
      drain();
      if (is_br || jmp[0]) exp_br++;
      if (op) exp_mis++;
      next_cycle();
      ex_valid = 1'b0;
   endtask

   initial begin
      cpu_rst_n = 1'b0; pred_en = 1'b1; if_pc = 32'h100;
      ex_valid = 1'b1; ex_pc = 32'h100; ex_is_branch = 1'b0; ex_funct3 = 3'b000;
      ex_jump = 2'b11; ex_zero = 1'b0; ex_sgn = 1'b0; ex_ult = 1'b0;
      ex_pcimm = 32'h500; ex_alu_c = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
      #3;
      push("rst.ptk", S_PTK, 32'd0);
      push("rst.ptgt", S_PTGT, 32'h104);
      push("rst.op", S_OP, 32'd0);
      push("rst.flush", S_FL, 32'd0);
      push("rst.bj", S_BJ, 32'h104);
      push("rst.br", S_BR, 32'd0);
      push("rst.mis", S_MIS, 32'd0);
      drain();
      repeat (2) @(posedge cpu_clk);
      #1;
      cpu_rst_n = 1'b1; ex_valid = 1'b0;
      next_cycle();

      // allocation on taken beq, lookup sees the old (empty) entry same cycle
      push_lookup("a.same", 32'h100, 1'b0, 32'h104);
      resolve("a.beq", 32'h100, 1, 3'b000, 2'b00, 1, 0, 0, 32'h140, 0, 0, 0, 1, 32'h140);
      look("a.look", 32'h100, 1'b1, 32'h140);

      // counter walks down 10->01->00->00, then one taken -> 01 (still not taken)
      resolve("b.nt1", 32'h100, 1, 3'b000, 2'b00, 0, 0, 0, 32'h140, 0, 1, 32'h140, 1, 32'h104);
      look("b.look1", 32'h100, 1'b0, 32'h104);
      resolve("b.nt2", 32'h100, 1, 3'b000, 2'b00, 0, 0, 0, 32'h140, 0, 0, 0, 0, 32'h104);
      look("b.look2", 32'h100, 1'b0, 32'h104);
      resolve("b.nt3", 32'h100, 1, 3'b000, 2'b00, 0, 0, 0, 32'h140, 0, 0, 0, 0, 32'h104);
      resolve("b.tk", 32'h100, 1, 3'b000, 2'b00, 1, 0, 0, 32'h140, 0, 0, 0, 1, 32'h140);
      look("b.sat", 32'h100, 1'b0, 32'h104);

      // branch condition decode
      resolve("c.bltu", 32'h400, 1, 3'b110, 2'b00, 0, 0, 1, 32'h480, 0, 0, 0, 1, 32'h480);
      resolve("c.bgeu", 32'h404, 1, 3'b111, 2'b00, 0, 0, 1, 32'h4a0, 0, 0, 0, 0, 32'h408);
      resolve("c.blt", 32'h408, 1, 3'b100, 2'b00, 0, 1, 0, 32'h4c0, 0, 0, 0, 1, 32'h4c0);
      resolve("c.bge", 32'h40c, 1, 3'b101, 2'b00, 0, 1, 0, 32'h4d0, 0, 1, 32'h4d0, 1, 32'h410);
      resolve("c.bne", 32'h410, 1, 3'b001, 2'b00, 1, 0, 0, 32'h4e0, 0, 0, 0, 0, 32'h414);
      resolve("c.f010", 32'h414, 1, 3'b010, 2'b00, 1, 1, 1, 32'h4f0, 0, 0, 0, 0, 32'h418);
      look("c.look_blt", 32'h408, 1'b1, 32'h4c0);
      look("c.look_bgeu", 32'h404, 1'b0, 32'h408);

      // jalr target LSB clear, stale target retrain, jal allocation
      resolve("d.jalr1", 32'h200, 0, 3'b000, 2'b01, 0, 0, 0, 32'h999, 32'h301, 1, 32'h300, 0, 32'h300);
      look("d.look1", 32'h200, 1'b1, 32'h300);
      resolve("d.jalr2", 32'h200, 0, 3'b000, 2'b01, 0, 0, 0, 32'h999, 32'h333, 1, 32'h300, 1, 32'h332);
      look("d.look2", 32'h200, 1'b1, 32'h332);
      resolve("d.jal", 32'h604, 0, 3'b000, 2'b11, 0, 0, 0, 32'h800, 32'h123, 0, 0, 1, 32'h800);
      look("d.look_jal", 32'h604, 1'b1, 32'h800);

      // eviction by a same-index, different-tag PC
      resolve("e.alloc", 32'h100, 1, 3'b000, 2'b00, 1, 0, 0, 32'h180, 0, 0, 0, 1, 32'h180);
      look("e.look", 32'h100, 1'b1, 32'h180);
      push_lookup("e.same", 32'h100, 1'b1, 32'h180);
      resolve("e.evict", 32'h140, 1, 3'b001, 2'b00, 0, 0, 0, 32'h1a0, 0, 0, 0, 1, 32'h1a0);
      look("e.gone", 32'h100, 1'b0, 32'h104);
      look("e.new", 32'h140, 1'b1, 32'h1a0);

      // alias on a non-control instruction clears the entry
      resolve("f.alias", 32'h140, 0, 3'b000, 2'b00, 0, 0, 0, 32'h0, 0, 1, 32'h1a0, 1, 32'h144);
      look("f.cleared", 32'h140, 1'b0, 32'h144);
      resolve("f.plain", 32'h144, 0, 3'b000, 2'b00, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h148);

      // static not-taken still trains
      pred_en = 1'b0;
      resolve("g.train", 32'h300, 1, 3'b000, 2'b00, 1, 0, 0, 32'h380, 0, 0, 0, 1, 32'h380);
      look("g.off", 32'h300, 1'b0, 32'h304);
      pred_en = 1'b1;
      look("g.on", 32'h300, 1'b1, 32'h380);

      // ex_valid low: no redirect, no training, no counting
      ex_valid = 1'b0; ex_pc = 32'h300; ex_is_branch = 1'b1; ex_funct3 = 3'b000;
      ex_jump = 2'b00; ex_zero = 1'b1; ex_pcimm = 32'h999; ex_pred_taken = 1'b0;
      push("h.op", S_OP, 32'd0);
      push("h.flush", S_FL, 32'd0);
      #2;
      drain();
      next_cycle();
      look("h.after", 32'h300, 1'b1, 32'h380);

      // asynchronous reset mid-cycle with counters nonzero
      if_pc = 32'h300; ex_valid = 1'b1; ex_pcimm = 32'h380;
      cpu_rst_n = 1'b0;
      exp_br = 0; exp_mis = 0;
      #1;
      push("i.ptk", S_PTK, 32'd0);
      push("i.ptgt", S_PTGT, 32'h304);
      push("i.op", S_OP, 32'd0);
      push("i.flush", S_FL, 32'd0);
      push("i.bj", S_BJ, 32'h304);
      push("i.br", S_BR, 32'd0);
      push("i.mis", S_MIS, 32'd0);
      drain();
      next_cycle();
      ex_valid = 1'b0; cpu_rst_n = 1'b1;
      next_cycle();
      look("i.after", 32'h300, 1'b0, 32'h304);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
